isp_frame_cfg_ctrl: RTL and testbench

- Frame-synchronous configuration controller for the ISP raw pipeline (dpc/blc/bnr/dgain and later stages).
- Host writes stage enables and tuning registers into a shadow bank over a req/ack bus. On request, the shadow bank is committed atomically to the active bank at the next frame start (rising in_vsync).
- Also checks input frame geometry against WIDTH/HEIGHT and counts frames.
- Sits between the host/I2C register bridge and the pipeline's enable/parameter inputs.

---
 rtl/isp_frame_cfg_ctrl.sv | 150 +++++++++++++++
 tb/tb_isp_frame_cfg_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_frame_cfg_ctrl.sv
// Frame-synchronous configuration controller: host shadow bank, atomic commit to
// the active bank on frame start (or after an idle timeout), geometry check, frame count.
module isp_frame_cfg_ctrl #(
   parameter int unsigned WIDTH      = 1280,
   parameter int unsigned HEIGHT     = 960,
   parameter int unsigned NUM_STAGES = 13,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned ADDR_BITS  = 6,
   parameter int unsigned DATA_BITS  = 16,
   parameter int unsigned TIMEOUT    = 1048576
) (
   input  logic                                pclk,
   input  logic                                rst_n,
   input  logic                                cfg_req,
   input  logic                                cfg_we,
   input  logic [ADDR_BITS-1:0]                cfg_addr,
   input  logic [DATA_BITS-1:0]                cfg_wdata,
   output logic                                cfg_ack,
   output logic [DATA_BITS-1:0]                cfg_rdata,
   input  logic                                commit_req,
   input  logic                                in_href,
   input  logic                                in_vsync,
   output logic [NUM_STAGES-1:0]               stage_en_o,
   output logic [(NUM_REGS-1)*DATA_BITS-1:0]   reg_o,
   output logic                                commit_pending,
   output logic                                commit_done,
   output logic [15:0]                         frame_cnt,
   output logic [1:0]                          geom_err
);

   localparam int unsigned PW = $clog2(WIDTH + 1) + 1;
   localparam int unsigned LW = $clog2(HEIGHT + 1) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned RW = (NUM_REGS - 1) * DATA_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_REG = ADDR_BITS'(NUM_REGS - 1);
   localparam logic [ADDR_BITS-1:0] STATUS   = '1;
   localparam logic [TW-1:0]        T_LAST   = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0]        W_EXP    = PW'(WIDTH);
   localparam logic [LW-1:0]        H_EXP    = LW'(HEIGHT);

   typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

   state_t                  state;
   logic                    vs_q, hr_q;
   logic                    vs_rise, vs_fall, hr_rise, hr_fall;
   logic [NUM_STAGES-1:0]   sh_en;
   logic [RW-1:0]           sh_regs;
   logic [TW-1:0]           tcnt;
   logic [PW-1:0]           pix_cnt;
   logic [LW-1:0]           line_cnt;
   logic                    accept, wr, rd;
   logic [DATA_BITS-1:0]    rd_val;
   logic [1:0]              geom_set, geom_clr;

   always_comb begin
      vs_rise = in_vsync & ~vs_q;
      vs_fall = ~in_vsync & vs_q;
      hr_rise = in_href & ~hr_q;
      hr_fall = ~in_href & hr_q;
      // Bank writes wait until the commit has fully landed; reads and status never stall.
      accept  = cfg_req & ~cfg_ack & ~(cfg_we & (cfg_addr <= LAST_REG) & (state != IDLE));
      wr      = accept & cfg_we;
      rd      = accept & ~cfg_we;
      geom_clr    = (wr && cfg_addr == STATUS) ? cfg_wdata[1:0] : 2'b00;
      geom_set[0] = hr_fall & (pix_cnt != W_EXP);
      geom_set[1] = vs_fall & (line_cnt != H_EXP);
      rd_val = '0;
      if (cfg_addr == '0)
         rd_val = DATA_BITS'(sh_en);
      for (int unsigned i = 1; i < NUM_REGS; i++)
         if (cfg_addr == ADDR_BITS'(i))
            rd_val = sh_regs[(i - 1) * DATA_BITS +: DATA_BITS];
      if (cfg_addr == STATUS)
         rd_val = DATA_BITS'({geom_err, commit_pending, frame_cnt[3:0]});
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         vs_q           <= 1'b0;
         hr_q           <= 1'b0;
         cfg_ack        <= 1'b0;
         cfg_rdata      <= '0;
         sh_en          <= '0;
         sh_regs        <= '0;
         stage_en_o     <= '0;
         reg_o          <= '0;
         commit_pending <= 1'b0;
         commit_done    <= 1'b0;
         frame_cnt      <= '0;
         geom_err       <= '0;
         tcnt           <= '0;
         pix_cnt        <= '0;
         line_cnt       <= '0;
      end else begin
         vs_q    <= in_vsync;
         hr_q    <= in_href;
         cfg_ack <= accept;
         if (rd)
            cfg_rdata <= rd_val;
         if (wr) begin
            if (cfg_addr == '0)
               sh_en <= cfg_wdata[NUM_STAGES-1:0];
            for (int unsigned i = 1; i < NUM_REGS; i++)
               if (cfg_addr == ADDR_BITS'(i))
                  sh_regs[(i - 1) * DATA_BITS +: DATA_BITS] <= cfg_wdata;
         end

         geom_err <= (geom_err & ~geom_clr) | geom_set;
         if (vs_rise)
            frame_cnt <= frame_cnt + 16'd1;
         // Counters saturate so overlong lines/frames can never alias to the expected size.
         if (hr_rise)
            pix_cnt <= PW'(1);
         else if (in_href && pix_cnt != '1)
            pix_cnt <= pix_cnt + PW'(1);
         if (vs_rise)
            line_cnt <= hr_rise ? LW'(1) : '0;
         else if (hr_rise && in_vsync && line_cnt != '1)
            line_cnt <= line_cnt + LW'(1);

         commit_done <= 1'b0;
         case (state)
            IDLE: begin
               if (commit_req) begin
                  state          <= PENDING;
                  commit_pending <= 1'b1;
                  tcnt           <= '0;
               end
            end
            PENDING: begin
               if (vs_rise || (tcnt >= T_LAST && !in_vsync && !in_href)) begin
                  state          <= APPLY;
                  commit_pending <= 1'b0;
               end else if (tcnt != T_LAST) begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            APPLY: begin
               stage_en_o  <= sh_en;
               reg_o       <= sh_regs;
               commit_done <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isp_frame_cfg_ctrl.sv
// Self-checking bench for isp_frame_cfg_ctrl: register-map vectors, commit timing
// sequences, geometry frames and a randomized phase against a transaction-level model.
module tb_isp_frame_cfg_ctrl;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int TO = 64;
   localparam int NS = 13;
   localparam int NR = 32;
   localparam int AB = 6;
   localparam int DB = 16;
   localparam int RW = (NR - 1) * DB;

   logic              pclk = 1'b0;
   logic              rst_n;
   logic              cfg_req, cfg_we;
   logic [AB-1:0]     cfg_addr;
   logic [DB-1:0]     cfg_wdata;
   logic              cfg_ack;
   logic [DB-1:0]     cfg_rdata;
   logic              commit_req, in_href, in_vsync;
   logic [NS-1:0]     stage_en_o;
   logic [RW-1:0]     reg_o;
   logic              commit_pending, commit_done;
   logic [15:0]       frame_cnt;
   logic [1:0]        geom_err;

   isp_frame_cfg_ctrl #(
      .WIDTH(W), .HEIGHT(H), .NUM_STAGES(NS), .NUM_REGS(NR),
      .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO)
   ) dut (
      .pclk(pclk), .rst_n(rst_n),
      .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
      .commit_req(commit_req), .in_href(in_href), .in_vsync(in_vsync),
      .stage_en_o(stage_en_o), .reg_o(reg_o),
      .commit_pending(commit_pending), .commit_done(commit_done),
      .frame_cnt(frame_cnt), .geom_err(geom_err)
   );

   always #5 pclk = ~pclk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;

   always @(posedge pclk) begin
      cyc <= cyc + 1;
      if (commit_done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Transaction-level model of the register banks and observable status
   logic [15:0] m_sh [NR];
   logic [15:0] m_act [NR];
   int          m_frames, m_lines, m_commits;
   logic [1:0]  m_geom;

   function automatic void m_clear();
      for (int i = 0; i < NR; i++) begin
         m_sh[i]  = 16'h0;
         m_act[i] = 16'h0;
      end
      m_frames = 0;
      m_lines  = 0;
      m_geom   = 2'b00;
   endfunction

   function automatic void m_write(input logic [AB-1:0] a, input logic [15:0] d);
      if (a == 6'd0)
         m_sh[0] = d & 16'((1 << NS) - 1);
      else if (int'(a) < NR)
         m_sh[int'(a)] = d;
      else if (a == 6'h3F)
         m_geom = m_geom & ~d[1:0];
   endfunction

   function automatic logic [15:0] m_read(input logic [AB-1:0] a, input logic pend);
      if (int'(a) < NR) return m_sh[int'(a)];
      if (a == 6'h3F) return {9'b0, m_geom, pend, 4'(m_frames)};
      return 16'h0;
   endfunction

   function automatic void m_commit();
      for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
      m_commits++;
   endfunction

   function automatic logic [RW-1:0] exp_regs();
      logic [RW-1:0] r;
      r = '0;
      for (int i = 1; i < NR; i++) r[(i - 1) * DB +: DB] = m_act[i];
      return r;
   endfunction

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic host(input logic we, input logic [AB-1:0] a, input logic [15:0] d,
                       output logic [15:0] rdv, output int lat);
      cfg_we = we; cfg_addr = a; cfg_wdata = d; cfg_req = 1'b1;
      lat = 0;
      for (int k = 0; k < 300; k++) begin
         tick();
         lat++;
         if (cfg_ack) break;
      end
      if (!cfg_ack) begin
         checks++;
         errors++;
         $display("FAIL host_ack_timeout: addr %0d got no ack within %0d cycles", a, lat);
      end
      rdv = cfg_rdata;
      cfg_req = 1'b0;
   endtask

   task automatic vs_up();
      in_vsync = 1'b1;
      m_frames++;
      m_lines = 0;
   endtask

   task automatic vs_down();
      in_vsync = 1'b0;
      if (m_lines != H) m_geom[1] = 1'b1;
      repeat (3) tick();
   endtask

   task automatic run_line(input int px);
      in_href = 1'b1;
      if (in_vsync) m_lines++;
      repeat (px) tick();
      in_href = 1'b0;
      if (px != W) m_geom[0] = 1'b1;
      repeat (2) tick();
   endtask

   task automatic frame_rest(input int nl, input int px, input int bad);
      for (int l = 0; l < nl; l++) run_line(l == bad ? px - 1 : px);
      vs_down();
   endtask

   task automatic frame(input int nl, input int px, input int bad);
      vs_up();
      repeat (2) tick();
      frame_rest(nl, px, bad);
   endtask

   task automatic pulse_commit();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
   endtask

   typedef struct {
      logic          we;
      logic [AB-1:0] addr;
      logic [15:0]   wdata;
      logic [15:0]   exp;
   } vec_t;

   vec_t        tbl [16];
   logic [15:0] rd, rd2;
   int          lat, wlat, n, ack_cyc, done_cyc, d0;
   logic        pend_mid;

   initial begin
      tbl[0]  = '{1'b1, 6'd0,  16'hFFFF, 16'h0000};
      tbl[1]  = '{1'b0, 6'd0,  16'h0000, 16'h1FFF};
      tbl[2]  = '{1'b1, 6'd5,  16'hBEEF, 16'h0000};
      tbl[3]  = '{1'b0, 6'd5,  16'h0000, 16'hBEEF};
      tbl[4]  = '{1'b1, 6'd31, 16'hA5A5, 16'h0000};
      tbl[5]  = '{1'b0, 6'd31, 16'h0000, 16'hA5A5};
      tbl[6]  = '{1'b1, 6'd40, 16'h1234, 16'h0000};
      tbl[7]  = '{1'b0, 6'd40, 16'h0000, 16'h0000};
      tbl[8]  = '{1'b1, 6'd32, 16'h7777, 16'h0000};
      tbl[9]  = '{1'b0, 6'd32, 16'h0000, 16'h0000};
      tbl[10] = '{1'b0, 6'd63, 16'h0000, 16'h0000};
      tbl[11] = '{1'b1, 6'd0,  16'h000F, 16'h0000};
      tbl[12] = '{1'b0, 6'd0,  16'h0000, 16'h000F};
      tbl[13] = '{1'b0, 6'd1,  16'h0000, 16'h0000};
      tbl[14] = '{1'b1, 6'd63, 16'h0003, 16'h0000};
      tbl[15] = '{1'b0, 6'd63, 16'h0000, 16'h0000};

      m_clear();
      m_commits = 0;
      rst_n = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      commit_req = 1'b0; in_href = 1'b0; in_vsync = 1'b0;
      repeat (3) tick();
      check("rst_stage_en", stage_en_o, '0);
      check("rst_reg_o", reg_o, '0);
      check("rst_ack_pend_done", {cfg_ack, commit_pending, commit_done}, '0);
      check("rst_frame_geom", {frame_cnt, geom_err}, '0);
      check("rst_rdata", cfg_rdata, '0);
      rst_n = 1'b1;
      tick();

      // register map vectors
      for (int i = 0; i < 16; i++) begin
         host(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, lat);
         check($sformatf("vec%0d_ack_latency", i), lat, 1);
         if (tbl[i].we) m_write(tbl[i].addr, tbl[i].wdata);
         else check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
         tick();
      end
      check("no_commit_stage_en", stage_en_o, '0);

      // commit requested mid-frame lands at the next frame start
      vs_up(); repeat (2) tick();
      run_line(W); run_line(W);
      pulse_commit();
      check("sync_pending", commit_pending, 1);
      run_line(W); run_line(W);
      vs_down();
      check("sync_hold_stage_en", stage_en_o, '0);
      check("sync_hold_reg_o", reg_o, '0);
      check("sync_still_pending", commit_pending, 1);
      vs_up(); tick();
      check("sync_done_early", commit_done, 0);
      check("sync_stage_en_early", stage_en_o, '0);
      tick();
      m_commit();
      check("sync_done", commit_done, 1);
      check("sync_stage_en", stage_en_o, 13'h000F);
      check("sync_slot5", reg_o[4 * DB +: DB], 16'hBEEF);
      check("sync_reg_o", reg_o, exp_regs());
      check("sync_frame_cnt", frame_cnt, 16'(m_frames));
      tick();
      check("sync_done_single", commit_done, 0);
      frame_rest(H, W, -1);
      check("sync_geom", geom_err, m_geom);

      // stalled bank write while pending, status read still served
      pulse_commit();
      host(1'b0, 6'h3F, 16'h0, rd, lat);
      check("stall_status_lat", lat, 1);
      check("stall_status_rdata", rd, m_read(6'h3F, 1'b1));
      done_cyc = -1;
      fork
         begin
            host(1'b1, 6'd2, 16'h0055, rd2, wlat);
            ack_cyc = cyc;
         end
         begin
            repeat (6) tick();
            pend_mid = commit_pending;
            vs_up();
            for (int k = 0; k < 20; k++) begin
               tick();
               if (commit_done) begin
                  done_cyc = cyc;
                  break;
               end
            end
         end
      join
      check("stall_pending_mid", pend_mid, 1);
      check("stall_commit_seen", done_cyc >= 0, 1);
      check("stall_write_waited", wlat > 6, 1);
      check("stall_ack_after_apply", ack_cyc >= done_cyc, 1);
      m_commit();
      m_write(6'd2, 16'h0055);
      check("stall_active_slot2", reg_o, exp_regs());
      host(1'b0, 6'd2, 16'h0, rd, lat);
      check("stall_read_slot2", rd, 16'h0055);
      frame_rest(H, W, -1);

      // forced commit after TIMEOUT quiet cycles
      host(1'b1, 6'd9, 16'h0909, rd, lat); m_write(6'd9, 16'h0909);
      tick();
      pulse_commit();
      check("to_pending", commit_pending, 1);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         n++;
         if (commit_done) break;
      end
      check("to_latency", n, TO + 1);
      m_commit();
      check("to_reg_o", reg_o, exp_regs());

      // commit_req together with a frame start, vsync held high blocks timeout
      host(1'b1, 6'd7, 16'h0707, rd, lat); m_write(6'd7, 16'h0707);
      tick();
      d0 = done_cnt;
      vs_up();
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      check("vsh_pending", commit_pending, 1);
      repeat (150) tick();
      check("vsh_no_commit", done_cnt - d0, 0);
      check("vsh_still_pending", commit_pending, 1);
      in_vsync = 1'b0;
      m_geom[1] = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n++;
         if (commit_done) break;
      end
      check("vsh_release_latency", n, 2);
      m_commit();
      check("vsh_reg_o", reg_o, exp_regs());
      tick();
      check("vsh_geom", geom_err, m_geom);
      host(1'b1, 6'h3F, 16'h0003, rd, lat); m_write(6'h3F, 16'h0003);
      tick();
      check("vsh_geom_clr", geom_err, m_geom);

      // geometry checks
      frame(H, W, -1);
      check("geo_good", geom_err, m_geom);
      frame(H, W, 1);
      check("geo_short_line", geom_err, m_geom);
      host(1'b0, 6'h3F, 16'h0, rd, lat);
      check("geo_status", rd, m_read(6'h3F, 1'b0));
      host(1'b1, 6'h3F, 16'h0001, rd, lat); m_write(6'h3F, 16'h0001);
      tick();
      check("geo_clr0", geom_err, m_geom);
      frame(H - 1, W, -1);
      check("geo_few_lines", geom_err, m_geom);
      host(1'b1, 6'h3F, 16'h0003, rd, lat); m_write(6'h3F, 16'h0003);
      tick();
      check("geo_clr_both", geom_err, 2'b00);
      check("geo_frame_cnt", frame_cnt, 16'(m_frames));

      // randomized traffic against the model
      for (int it = 0; it < 60; it++) begin
         int op;
         logic [AB-1:0] a;
         logic [15:0] d;
         op = $urandom_range(0, 9);
         a = ($urandom_range(0, 9) < 7) ? AB'($urandom_range(0, NR - 1)) : AB'($urandom_range(NR, 63));
         d = 16'($urandom);
         if (op <= 3) begin
            host(1'b1, a, d, rd, lat);
            m_write(a, d);
            check("rnd_wr_lat", lat, 1);
            tick();
         end else if (op <= 7) begin
            host(1'b0, a, 16'h0, rd, lat);
            check($sformatf("rnd_rd_a%0d", a), rd, m_read(a, 1'b0));
            tick();
         end else begin
            int nl, px, bad;
            nl  = $urandom_range(H - 1, H + 1);
            px  = $urandom_range(W - 1, W + 1);
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
            d0 = done_cnt;
            pulse_commit();
            frame(nl, px, bad);
            m_commit();
            check("rnd_commit_once", done_cnt - d0, 1);
            check("rnd_stage_en", stage_en_o, m_act[0][NS-1:0]);
            check("rnd_reg_o", reg_o, exp_regs());
            check("rnd_frame_cnt", frame_cnt, 16'(m_frames));
            check("rnd_geom", geom_err, m_geom);
         end
      end
      check("commit_count", done_cnt, m_commits);

      // asynchronous reset in the middle of a pending commit
      host(1'b1, 6'd3, 16'h1234, rd, lat); m_write(6'd3, 16'h1234);
      tick();
      pulse_commit();
      repeat (3) tick();
      check("pre_rst_pending", commit_pending, 1);
      rst_n = 1'b0;
      #2;
      check("arst_stage_en", stage_en_o, '0);
      check("arst_reg_o", reg_o, '0);
      check("arst_pend_done", {commit_pending, commit_done, cfg_ack}, '0);
      check("arst_frame_geom", {frame_cnt, geom_err}, '0);
      check("arst_rdata", cfg_rdata, '0);
      tick();
      rst_n = 1'b1;
      m_clear();
      tick();
      host(1'b0, 6'd3, 16'h0, rd, lat);
      check("arst_slot3_cleared", rd, 16'h0000);
      d0 = done_cnt;
      repeat (TO + 20) tick();
      check("arst_commit_discarded", done_cnt - d0, 0);
      check("arst_reg_o_after", reg_o, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
